// File: rtl/dcfifo_read_adapter_pkg.sv
// rtl/dcfifo_read_adapter_pkg.sv - shared constants and width helpers for the dcfifo read adapter
package dcfifo_read_adapter_pkg;

  localparam int STAT_W    = 32;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dcfifo_read_adapter_if.sv
// rtl/dcfifo_read_adapter_if.sv - FIFO read port plus valid/ready output stream bundle
interface dcfifo_read_adapter_if #(
  parameter int WIDTH = 8
);

  logic             fifo_rdempty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  fifo_rdempty, fifo_q, out_ready,
    output fifo_rdreq, out_valid, out_data
  );

  modport slave (
    output fifo_rdempty, fifo_q, out_ready,
    input  fifo_rdreq, out_valid, out_data
  );

endinterface

// File: rtl/dcfifo_read_adapter_buf.sv
// rtl/dcfifo_read_adapter_buf.sv - circular word store with head/tail pointers wrapping modulo DEPTH
module dcfifo_read_adapter_buf
  import dcfifo_read_adapter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (rd_en_i) head_d = next_ptr(head_q);
    if (wr_en_i) tail_d = next_ptr(tail_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[tail_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[head_q];

endmodule

// File: rtl/dcfifo_read_adapter.sv
// rtl/dcfifo_read_adapter.sv - non-showahead dcfifo read port to valid/ready stream; DCFIFO_READ_ADAPTER_STATS_EN adds stat counters
module dcfifo_read_adapter
  import dcfifo_read_adapter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  dcfifo_read_adapter_if.master     bus,
  output logic [level_w(DEPTH)-1:0] level
`ifdef DCFIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_words,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int LW = level_w(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("dcfifo_read_adapter: DEPTH out of range");
  end

  logic [LW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [LW:0]   credit_used;
  logic          push;
  logic          pop;

  // A slot is reserved for the in-flight word, so back-pressure can never overflow the store.
  assign credit_used    = {1'b0, count_q} + {{LW{1'b0}}, inflight_q};
  assign bus.fifo_rdreq = ~reset & ~bus.fifo_rdempty & (credit_used < (LW+1)'(DEPTH));

  assign push          = inflight_q;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = (count_q != '0);
  assign level         = count_q;
  assign inflight_d    = bus.fifo_rdreq;

  always_comb begin
    count_d = count_q;
    if (push & ~pop)      count_d = count_q + LW'(1);
    else if (pop & ~push) count_d = count_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  dcfifo_read_adapter_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (push),
    .wr_data_i (bus.fifo_q),
    .rd_en_i   (pop),
    .rd_data_o (bus.out_data)
  );

`ifdef DCFIFO_READ_ADAPTER_STATS_EN
  logic [STAT_W-1:0] words_q, words_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (pop && words_q != '1) words_d = words_q + STAT_W'(1);
    if (bus.out_valid && !bus.out_ready && stall_q != '1) stall_d = stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_dcfifo_read_adapter.sv
// tb/tb_dcfifo_read_adapter.sv - self-checking bench with a queue-based FIFO model and scoreboard
module tb_dcfifo_read_adapter;

  logic clk;
  logic reset0, reset1;
  logic [2:0] level0;
  logic [1:0] level1;
`ifdef DCFIFO_READ_ADAPTER_STATS_EN
  logic [31:0] sw0, ss0, sw1, ss1;
`endif

  dcfifo_read_adapter_if #(.WIDTH(8)) if0 ();
  dcfifo_read_adapter_if #(.WIDTH(8)) if1 ();

  dcfifo_read_adapter #(.WIDTH(8), .DEPTH(4)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (if0.master),
    .level (level0)
`ifdef DCFIFO_READ_ADAPTER_STATS_EN
    ,
    .stat_words (sw0),
    .stat_stall (ss0)
`endif
  );

  dcfifo_read_adapter #(.WIDTH(8), .DEPTH(3)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (if1.master),
    .level (level1)
`ifdef DCFIFO_READ_ADAPTER_STATS_EN
    ,
    .stat_words (sw1),
    .stat_stall (ss1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  int cyc;
  logic [7:0] mq0[$], exp0[$], mq1[$], exp1[$];
  logic pend0, pend1, force_empty0;
  logic s_rdreq0, s_valid0, s_rdreq1, s_valid1;
  logic [7:0] s_data0, s_data1;
  logic [2:0] s_level0;
  int xfers0, gaps0, last0, xfers1, first1, last1, viol, max_level0;
  logic [7:0] first_data0;

  // One clock: present inputs, sample mid-cycle, then let the FIFO model answer prior requests.
  task automatic tick();
    if0.fifo_rdempty = (mq0.size() == 0) || force_empty0;
    if1.fifo_rdempty = (mq1.size() == 0);
    @(negedge clk);
    s_rdreq0 = if0.fifo_rdreq; s_valid0 = if0.out_valid; s_data0 = if0.out_data; s_level0 = level0;
    s_rdreq1 = if1.fifo_rdreq; s_valid1 = if1.out_valid; s_data1 = if1.out_data;
    if ((s_rdreq0 && if0.fifo_rdempty) || (s_rdreq1 && if1.fifo_rdempty)) viol++;
    if (int'(s_level0) > max_level0) max_level0 = int'(s_level0);
    if (s_valid0 && if0.out_ready) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++; $display("FAIL sb0_extra: got %0h want none", s_data0);
      end else begin
        if (s_data0 !== exp0[0]) begin
          errors++; $display("FAIL sb0_data: got %0h want %0h", s_data0, exp0[0]);
        end
        void'(exp0.pop_front());
      end
      if (xfers0 == 0) first_data0 = s_data0;
      else if (cyc != last0 + 1) gaps0++;
      last0 = cyc; xfers0++;
    end
    if (s_valid1 && if1.out_ready) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++; $display("FAIL sb1_extra: got %0h want none", s_data1);
      end else begin
        if (s_data1 !== exp1[0]) begin
          errors++; $display("FAIL sb1_data: got %0h want %0h", s_data1, exp1[0]);
        end
        void'(exp1.pop_front());
      end
      if (xfers1 == 0) first1 = cyc;
      last1 = cyc; xfers1++;
    end
    pend0 = s_rdreq0;
    pend1 = s_rdreq1;
    @(posedge clk);
    #1;
    cyc++;
    if (pend0) if0.fifo_q = (mq0.size() > 0) ? mq0.pop_front() : 8'h00;
    if (pend1) if1.fifo_q = (mq1.size() > 0) ? mq1.pop_front() : 8'h00;
  endtask

  task automatic load0(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      mq0.push_back(w);
      exp0.push_back(w);
    end
  endtask

  task automatic test_reset();
    reset0 = 1'b1;
    mq0.push_back(8'h11); mq0.push_back(8'h22); mq0.push_back(8'h33);
    exp0.push_back(8'h11); exp0.push_back(8'h22); exp0.push_back(8'h33);
    tick(); tick();
    checks++; if (s_rdreq0 !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %0b want 0", s_rdreq0); end
    checks++; if (s_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", s_valid0); end
    checks++; if (s_level0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", s_level0); end
  endtask

  task automatic test_latency();
    logic [7:0] want [3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    reset0 = 1'b0;
    if0.out_ready = 1'b1;
    tick();
    checks++; if (s_rdreq0 !== 1'b1) begin errors++; $display("FAIL lat_rdreq_c0: got %0b want 1", s_rdreq0); end
    tick();
    checks++; if (s_valid0 !== 1'b0) begin errors++; $display("FAIL lat_valid_c1: got %0b want 0", s_valid0); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (s_valid0 !== 1'b1 || s_data0 !== want[k]) begin
        errors++; $display("FAIL lat_word%0d: got v=%0b d=%0h want v=1 d=%0h", k, s_valid0, s_data0, want[k]);
      end
    end
    tick();
    checks++; if (s_valid0 !== 1'b0) begin errors++; $display("FAIL lat_drained: got %0b want 0", s_valid0); end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    if0.out_ready = 1'b0;
    load0(10);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rdreq0) nreq++;
    end
    checks++; if (nreq != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", nreq); end
    checks++; if (s_level0 !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", s_level0); end
    checks++; if (s_rdreq0 !== 1'b0) begin errors++; $display("FAIL bp_rdreq_idle: got %0b want 0", s_rdreq0); end
    checks++;
    if (s_valid0 !== 1'b1 || s_data0 !== exp0[0]) begin
      errors++; $display("FAIL bp_hold: got v=%0b d=%0h want v=1 d=%0h", s_valid0, s_data0, exp0[0]);
    end
    xfers0 = 0; gaps0 = 0;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp0.size() > 0; i++) tick();
    checks++; if (xfers0 != 10) begin errors++; $display("FAIL bp_count: got %0d want 10", xfers0); end
    checks++; if (gaps0 != 0) begin errors++; $display("FAIL bp_gaps: got %0d want 0", gaps0); end
  endtask

  task automatic test_empty_toggle();
    viol = 0; max_level0 = 0;
    load0(40);
    for (int i = 0; i < 1000 && exp0.size() > 0; i++) begin
      force_empty0 = i[0];
      if0.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    force_empty0 = 1'b0;
    if0.out_ready = 1'b1;
    tick(); tick();
    checks++; if (exp0.size() != 0) begin errors++; $display("FAIL tog_drain: got %0d left want 0", exp0.size()); end
    checks++; if (viol != 0) begin errors++; $display("FAIL tog_rdreq_empty: got %0d want 0", viol); end
    checks++; if (max_level0 > 4) begin errors++; $display("FAIL tog_level_max: got %0d want <=4", max_level0); end
  endtask

  task automatic test_depth3_throughput();
    int c0;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      mq1.push_back(w);
      exp1.push_back(w);
    end
    if1.out_ready = 1'b1;
    xfers1 = 0;
    reset1 = 1'b0;
    c0 = cyc;
    tick();
    checks++; if (s_rdreq1 !== 1'b1) begin errors++; $display("FAIL d3_rdreq_c0: got %0b want 1", s_rdreq1); end
    for (int i = 0; i < 300 && exp1.size() > 0; i++) tick();
    checks++; if (xfers1 != 100) begin errors++; $display("FAIL d3_count: got %0d want 100", xfers1); end
    checks++; if (first1 != c0 + 2) begin errors++; $display("FAIL d3_first: got %0d want %0d", first1 - c0, 2); end
    checks++; if (last1 != c0 + 101) begin errors++; $display("FAIL d3_last: got %0d want %0d", last1 - c0, 101); end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    if0.out_ready = 1'b0;
    load0(10);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_level0 == 3'd2 && s_rdreq0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rm_setup: got timeout want level2+rdreq"); end
    reset0 = 1'b1;
    tick();
    checks++; if (s_level0 !== 3'd3) begin errors++; $display("FAIL rm_pre_level: got %0d want 3", s_level0); end
    mq0.delete();
    exp0.delete();
    tick();
    checks++;
    if (s_level0 !== 3'd0 || s_valid0 !== 1'b0) begin
      errors++; $display("FAIL rm_cleared: got l=%0d v=%0b want l=0 v=0", s_level0, s_valid0);
    end
    reset0 = 1'b0;
    if0.out_ready = 1'b1;
    mq0.push_back(8'hA0); mq0.push_back(8'hA1); mq0.push_back(8'hA2);
    exp0.push_back(8'hA0); exp0.push_back(8'hA1); exp0.push_back(8'hA2);
    xfers0 = 0;
    for (int i = 0; i < 30 && exp0.size() > 0; i++) tick();
    checks++; if (xfers0 != 3) begin errors++; $display("FAIL rm_count: got %0d want 3", xfers0); end
    checks++; if (first_data0 !== 8'hA0) begin errors++; $display("FAIL rm_first: got %0h want a0", first_data0); end
  endtask

`ifdef DCFIFO_READ_ADAPTER_STATS_EN
  task automatic test_stats();
    reset0 = 1'b1;
    tick();
    checks++; if (sw0 !== 32'd0 || ss0 !== 32'd0) begin errors++; $display("FAIL st_reset: got w=%0d s=%0d want 0 0", sw0, ss0); end
    reset0 = 1'b0;
    if0.out_ready = 1'b0;
    load0(5);
    for (int i = 0; i < 10 && !s_valid0; i++) tick();
    tick(); tick();
    if0.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp0.size() > 0; i++) tick();
    checks++; if (sw0 !== 32'd5) begin errors++; $display("FAIL st_words: got %0d want 5", sw0); end
    checks++; if (ss0 !== 32'd3) begin errors++; $display("FAIL st_stall: got %0d want 3", ss0); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0;
    xfers0 = 0; gaps0 = 0; last0 = 0; xfers1 = 0; first1 = 0; last1 = 0;
    viol = 0; max_level0 = 0; first_data0 = 8'h00;
    pend0 = 1'b0; pend1 = 1'b0; force_empty0 = 1'b0;
    s_valid0 = 1'b0; s_valid1 = 1'b0; s_rdreq0 = 1'b0; s_rdreq1 = 1'b0;
    s_data0 = 8'h00; s_data1 = 8'h00; s_level0 = 3'd0;
    reset0 = 1'b1; reset1 = 1'b1;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    if0.fifo_q = 8'h00; if1.fifo_q = 8'h00;
    if0.fifo_rdempty = 1'b1; if1.fifo_rdempty = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_backpressure();
    test_empty_toggle();
    test_depth3_throughput();
    test_reset_mid();
`ifdef DCFIFO_READ_ADAPTER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
